// File: rtl/data_mem_subword.sv
// -----------------------------------------------------------------------------
// data_mem_subword
//   Byte-addressed, big-endian data memory with byte/halfword/word loads and
//   stores, sign/zero extension, alignment fault detection and a fixed-latency
//   response pipeline with backpressure.
//
// Parameters
//   ADDR_W    byte-address width (memory holds 2**ADDR_W bytes), 2..31
//   READ_LAT  cycles from request accept to response, 1..4
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       request present
//   req_ready       request can be accepted this cycle
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   req_unsigned    loads zero-extend when 1, sign-extend when 0
//   addr            byte address; bits above ADDR_W-1 ignored
//   wdata           right-justified store data
//   rsp_valid       response present
//   rsp_ready       consumer accepts the response
//   rdata           extended load result; 0 for stores and faults
//   misalign        response belongs to a faulted request
//   err_count       saturating count of faulted requests
// -----------------------------------------------------------------------------
module data_mem_subword #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [7:0]  err_count
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic        valid;
    logic        misalign;
    logic [31:0] rdata;
  } stage_t;

  // NOTE: memories carry no reset; contents survive rst_n and only start at
  // zero through the declaration initialiser.
  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  stage_t     stage_q [READ_LAT];
  stage_t     stage_d [READ_LAT];
  logic       ready_q, ready_d;
  logic [7:0] err_count_q, err_count_d;

  addr_t       a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [7:0]  wb0, wb1, wb2, wb3;
  logic        stall, accept, fault, do_store, sext;
  logic [31:0] load_data;

  // Upper address bits are deliberately dropped (modulo wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];

  // ---------------------------------------------------------------------------
  // Request decode, load extraction and store lane data
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    a0 = addr[ADDR_W-1:0];
    a1 = a0 + addr_t'(1);
    a2 = a0 + addr_t'(2);
    a3 = a0 + addr_t'(3);
    b0 = mem_q[a0];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];

    // A response stuck at the pipeline head freezes every stage.
    stall     = stage_q[READ_LAT-1].valid && !rsp_ready;
    req_ready = ready_q && !stall;
    accept    = req_valid && req_ready;

    case (req_size)
      SIZE_BYTE: fault = 1'b0;
      SIZE_HALF: fault = addr[0];
      SIZE_WORD: fault = |addr[1:0];
      default:   fault = 1'b1;
    endcase

    do_store = accept && req_write && !fault;
    sext     = !req_unsigned;

    // Big-endian: the lowest address holds the most significant byte.
    load_data = 32'h0;
    wb0 = 8'h00;
    wb1 = 8'h00;
    wb2 = 8'h00;
    wb3 = 8'h00;
    case (req_size)
      SIZE_BYTE: begin
        load_data = {{24{sext & b0[7]}}, b0};
        wb0       = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data = {{16{sext & b0[7]}}, b0, b1};
        wb0       = wdata[15:8];
        wb1       = wdata[7:0];
      end
      SIZE_WORD: begin
        load_data = {b0, b1, b2, b3};
        wb0       = wdata[31:24];
        wb1       = wdata[23:16];
        wb2       = wdata[15:8];
        wb3       = wdata[7:0];
      end
      default: begin
        load_data = 32'h0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state: response pipeline, ready, error counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_d = stage_q;
    if (!stall) begin
      stage_d[0] = '0;
      if (accept) begin
        stage_d[0].valid    = 1'b1;
        stage_d[0].misalign = fault;
        stage_d[0].rdata    = (fault || req_write) ? 32'h0 : load_data;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Held low by reset; rises on the first edge after release.
    ready_d = 1'b1;

    err_count_d = err_count_q;
    if (accept && fault && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stage_q[i] <= '0;
      end
      ready_q     <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      stage_q     <= stage_d;
      ready_q     <= ready_d;
      err_count_q <= err_count_d;
    end
  end

  // Memory writes: faulted stores never reach here; lanes beyond the access
  // size are left untouched.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem_q[a0] <= wb0;
      if (req_size != SIZE_BYTE) begin
        mem_q[a1] <= wb1;
      end
      if (req_size == SIZE_WORD) begin
        mem_q[a2] <= wb2;
        mem_q[a3] <= wb3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid = stage_q[READ_LAT-1].valid;
  assign rdata     = stage_q[READ_LAT-1].rdata;
  assign misalign  = stage_q[READ_LAT-1].misalign;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_data_mem_subword.sv
// -----------------------------------------------------------------------------
// tb_data_mem_subword
//   Directed bench for data_mem_subword (ADDR_W=8, READ_LAT=3): reset state,
//   big-endian sub-word loads/stores, extension, faults and the error counter,
//   address wrap, back-to-back throughput, backpressure and reset in flight.
// -----------------------------------------------------------------------------
module tb_data_mem_subword;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rdata;
  logic        misalign;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_subword #(
    .ADDR_W   (8),
    .READ_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rdata        (rdata),
    .misalign     (misalign),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One request, then wait (bounded) for its response with rsp_ready=1.
  // Returns at the negedge where the response is visible.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic mis);
    int lat;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    addr         = a;
    wdata        = wd;
    check({tag, "_ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd  = 32'h0;
    mis = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        rd  = rdata;
        mis = misalign;
        break;
      end
    end
    check({tag, "_lat"}, lat, LAT);
  endtask

  logic [31:0] rd;
  logic        mis;
  logic [31:0] d_bb [3] = '{32'h0102_0304, 32'hA5A5_F00F, 32'h7E7E_0101};
  int          n_rsp;
  logic [31:0] first_rsp;

  initial begin
    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_misalign", misalign, 0);
    check("rst_err_count", err_count, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", req_ready, 0);
    @(negedge clk);
    check("ready_after_edge", req_ready, 1);

    // ---------------- basic store / loads ----------------
    xact("sw_10", 1, 2'b10, 0, 32'h10, 32'h8123_4567, rd, mis);
    check("sw_10_rdata", rd, 32'h0);
    check("sw_10_mis", mis, 0);
    xact("lw_10", 0, 2'b10, 0, 32'h10, 0, rd, mis);
    check("lw_10", rd, 32'h8123_4567);
    check("lw_10_mis", mis, 0);
    xact("lb_10", 0, 2'b00, 0, 32'h10, 0, rd, mis);
    check("lb_10", rd, 32'hFFFF_FF81);
    xact("lbu_10", 0, 2'b00, 1, 32'h10, 0, rd, mis);
    check("lbu_10", rd, 32'h0000_0081);
    xact("lh_12", 0, 2'b01, 0, 32'h12, 0, rd, mis);
    check("lh_12", rd, 32'h0000_4567);
    xact("lh_10", 0, 2'b01, 0, 32'h10, 0, rd, mis);
    check("lh_10", rd, 32'hFFFF_8123);
    xact("lhu_10", 0, 2'b01, 1, 32'h10, 0, rd, mis);
    check("lhu_10", rd, 32'h0000_8123);
    xact("lb_12", 0, 2'b00, 0, 32'h12, 0, rd, mis);
    check("lb_12", rd, 32'h0000_0045);
    xact("lw_ulk", 0, 2'b10, 1, 32'h10, 0, rd, mis);
    check("lw_unsigned_flag", rd, 32'h8123_4567);

    // ---------------- byte store into a word ----------------
    xact("sb_11", 1, 2'b00, 0, 32'h11, 32'hFFFF_FFAA, rd, mis);
    xact("lw_10b", 0, 2'b10, 0, 32'h10, 0, rd, mis);
    check("lw_after_sb", rd, 32'h81AA_4567);
    check("err_before_faults", err_count, 0);

    // ---------------- faults ----------------
    xact("lw_02", 0, 2'b10, 0, 32'h02, 0, rd, mis);
    check("lw_02_mis", mis, 1);
    check("lw_02_rdata", rd, 32'h0);
    check("lw_02_err", err_count, 1);
    xact("sh_13", 1, 2'b01, 0, 32'h13, 32'h0000_BEEF, rd, mis);
    check("sh_13_mis", mis, 1);
    check("sh_13_err", err_count, 2);
    xact("lw_10c", 0, 2'b10, 0, 32'h10, 0, rd, mis);
    check("sh_13_no_write_lo", rd, 32'h81AA_4567);
    xact("lw_14", 0, 2'b10, 0, 32'h14, 0, rd, mis);
    check("sh_13_no_write_hi", rd, 32'h0);
    xact("rsv_10", 1, 2'b11, 0, 32'h10, 32'h0, rd, mis);
    check("rsv_mis", mis, 1);
    check("rsv_rdata", rd, 32'h0);
    check("rsv_err", err_count, 3);
    xact("lw_10d", 0, 2'b10, 0, 32'h10, 0, rd, mis);
    check("rsv_no_write", rd, 32'h81AA_4567);

    // ---------------- address wrap / top of memory ----------------
    xact("sw_1fc", 1, 2'b10, 0, 32'h1FC, 32'hCAFE_BABE, rd, mis);
    xact("lw_fc", 0, 2'b10, 0, 32'h0FC, 0, rd, mis);
    check("lw_fc", rd, 32'hCAFE_BABE);
    xact("lhu_2fe", 0, 2'b01, 1, 32'h2FE, 0, rd, mis);
    check("lhu_2fe", rd, 32'h0000_BABE);
    xact("lb_3fd", 0, 2'b00, 0, 32'h3FD, 0, rd, mis);
    check("lb_3fd", rd, 32'hFFFF_FFFE);
    xact("lh_fd", 0, 2'b01, 0, 32'h0FD, 0, rd, mis);
    check("lh_fd_mis", mis, 1);
    check("lh_fd_rdata", rd, 32'h0);
    check("lh_fd_err", err_count, 4);

    // ---------------- back-to-back loads ----------------
    for (int k = 0; k < 3; k++) begin
      xact("sw_bb", 1, 2'b10, 0, 32'(4 * k), d_bb[k], rd, mis);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    addr      = 32'h0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c < 3) addr = 32'(4 * c);
      else req_valid = 1'b0;
      @(negedge clk);
      check("bb_valid", rsp_valid, (c >= 3 && c <= 5) ? 1 : 0);
      if (c >= 3 && c <= 5) check("bb_rdata", rdata, d_bb[c-3]);
    end

    // ---------------- backpressure ----------------
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    addr      = 32'h0;
    @(posedge clk);
    #1 addr = 32'h4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_not_yet", rsp_valid, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_rdata", rdata, d_bb[0]);
      check("bp_hold_mis", misalign, 0);
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_ready_release", req_ready, 1);
    n_rsp     = 0;
    first_rsp = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (n_rsp == 0) first_rsp = rdata;
        n_rsp++;
      end
    end
    check("bp_release_count", n_rsp, 1);
    check("bp_release_rdata", first_rsp, d_bb[1]);

    // ---------------- reset with loads in flight ----------------
    check("err_before_reset", err_count, 4);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    addr      = 32'h0;
    @(posedge clk);
    #1 addr = 32'h4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 check("inflight_visible", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_if_valid", rsp_valid, 0);
    check("rst_if_rdata", rdata, 0);
    check("rst_if_mis", misalign, 0);
    check("rst_if_err", err_count, 0);
    check("rst_if_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check("rst_if_no_rsp", n_rsp, 0);
    xact("lw_kept", 0, 2'b10, 0, 32'h10, 0, rd, mis);
    check("store_survives_reset", rd, 32'h81AA_4567);
    xact("lw_kept0", 0, 2'b10, 0, 32'h0, 0, rd, mis);
    check("store_survives_reset_0", rd, d_bb[0]);

    // ---------------- error counter saturation ----------------
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    addr      = 32'h2;
    repeat (254) @(posedge clk);
    #1 check("err_254", err_count, 254);
    repeat (46) @(posedge clk);
    #1 req_valid = 1'b0;
    check("err_saturated", err_count, 255);
    repeat (6) @(negedge clk);
    check("drain_idle", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog: the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_subword.md
DATA_MEM_SUBWORD -- requirements
Module: data_mem_subword

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory holds 2^ADDR_W bytes.
REQ-002 Parameter READ_LAT, default 1, legal 1..4, cycles from request accept to response.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept the request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 addr  in  32  byte address; bits above ADDR_W-1 ignored (modulo wrap).
REQ-011 wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts the response.
REQ-014 rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 misalign  out  1  qualifies rsp_valid; response belongs to a faulted request.
REQ-016 err_count  out  8  saturating count of faulted requests.

Function
REQ-017 A request is accepted on a rising edge with req_valid && req_ready.
REQ-018 Byte order is big-endian: word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}; halfword = {mem[A], mem[A+1]}.
REQ-019 Store: the addressed 1, 2 or 4 bytes are written on the accept edge; other bytes are unchanged.
REQ-020 Load: memory is sampled on the accept edge; a store accepted on an earlier edge is always visible.
REQ-021 Every accepted request, store or load, produces exactly one response, in acceptance order.
REQ-022 With rsp_ready held 1, rsp_valid rises exactly READ_LAT cycles after the accept edge; one response per cycle at full throughput.
REQ-023 Backpressure: while rsp_valid && !rsp_ready, the READ_LAT-stage pipeline stalls, rsp_valid/rdata/misalign hold stable, and req_ready = 0.
REQ-024 Otherwise req_ready = 1; req_ready is combinationally independent of req_valid.
REQ-025 Fault: halfword with addr[0]=1, word with addr[1:0]!=00, or req_size=11; no memory write; response has misalign=1 and rdata=0.
REQ-026 err_count increments by 1 on each faulted accept and saturates at 255.
REQ-027 Aligned accesses never cross the top of memory; address wrap applies only through REQ-010 truncation.
REQ-028 Sign extension replicates bit 7 (byte) or bit 15 (halfword) of the loaded value; word loads are unaffected by req_unsigned.

Reset
REQ-029 While rst_n=0: rsp_valid=0, rdata=0, misalign=0, err_count=0, req_ready=0, all pipeline stages empty.
REQ-030 Requests in flight when reset asserts are discarded without responses; stores already written remain.
REQ-031 Memory contents are not cleared by reset; all bytes are initialised to 0 at time zero.
REQ-032 req_ready rises on the first rising edge after rst_n deasserts.

Verification
REQ-033 sw 0x8123_4567 @0x10, then lw @0x10 -> rdata 0x8123_4567; lb @0x10 -> 0xFFFF_FF81; lbu @0x10 -> 0x0000_0081; lh @0x12 -> 0x0000_4567.
REQ-034 sb 0xAA @0x11 over the above word, then lw @0x10 -> 0x81AA_4567.
REQ-035 lw @0x02 -> misalign=1, rdata=0, err_count 0->1; sh @0x13 -> no write, err_count 2; 300 faults -> err_count 255.
REQ-036 READ_LAT=3, back-to-back loads @0,4,8 with rsp_ready=1 -> three responses on consecutive cycles starting 3 cycles after the first accept, in order.
REQ-037 rsp_ready=0 for 5 cycles with a response pending -> rsp_valid, rdata, misalign stable; req_ready=0; no response lost or duplicated after release.
REQ-038 Assert rst_n=0 with 2 loads in flight -> outputs zero immediately; no responses after release; earlier stored data still readable.
